// File: rtl/alu_result_serializer.sv
// Buffers {ALU result, op select} words in a FIFO and streams them LSB-first as UART-style frames.
// Optional even-parity bit between payload and stop bit when ALU_SER_PARITY_EN is defined.
module alu_result_serializer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_data,
    input  logic [1:0]               in_sel,
    output logic                     tx_out,
    output logic                     tx_busy,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef struct packed {
        logic [5:0] data;
        logic [1:0] sel;
    } entry_t;

`ifdef ALU_SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               tx_d, busy_d, done_d;
    logic               pop, push, fifo_empty, baud_end;
`ifdef ALU_SER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    entry_t             head;

    assign in_ready   = (level != LVL_W'(DEPTH));
    assign fifo_empty = (level == '0);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign baud_end   = (baud_q == BAUD_LAST);

    // FIFO storage carries no reset; validity is tracked by level/pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_data, sel: in_sel};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FSM state, counters and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
`ifdef ALU_SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_out     <= tx_d;
            tx_busy    <= busy_d;
            frame_done <= done_d;
`ifdef ALU_SER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next state; outputs are derived from the next state so they line up with it after the edge
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        pop      = 1'b0;
`ifdef ALU_SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shreg_d  = head;
`ifdef ALU_SER_PARITY_EN
                    parity_d = ^head;
`endif
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef ALU_SER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef ALU_SER_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shreg_d  = head;
`ifdef ALU_SER_PARITY_EN
                        parity_d = ^head;
`endif
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef ALU_SER_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: scoreboarded frame receiver plus directed timing checks.
// Honors ALU_SER_PARITY_EN for frame length and parity expectations.
module tb_alu_result_serializer;

    localparam int DEPTH = 4;
    localparam int BAUD  = 4;
`ifdef ALU_SER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic       clk, rst;
    logic       in_valid, in_ready, tx_out, tx_busy, frame_done;
    logic [5:0] in_data;
    logic [1:0] in_sel;
    logic [2:0] level;

    logic       in_valid1, in_ready1, tx_out1, tx_busy1, frame_done1;
    logic [5:0] in_data1;
    logic [1:0] in_sel1;
    logic [2:0] level1;

    alu_result_serializer #(.DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .tx_out(tx_out), .tx_busy(tx_busy),
        .frame_done(frame_done), .level(level)
    );

    alu_result_serializer #(.DEPTH(DEPTH), .BAUD_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_sel(in_sel1), .tx_out(tx_out1), .tx_busy(tx_busy1),
        .frame_done(frame_done1), .level(level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          n_frames = 0;
    int          n_expected = 0;
    logic [7:0]  exp_q[$];
    logic        rx_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Frame receiver: decodes frames from the line and compares payloads against the scoreboard
    logic [7:0] rx_got;
    logic       rx_bad;
    int         rx_fd;
    always begin : rx_proc
        @(negedge clk);
        if (rx_en && !rst && tx_out === 1'b0) begin
            rx_bad = 1'b0;
            rx_fd  = 0;
            rx_got = '0;
            if (tx_busy !== 1'b1 || frame_done !== 1'b0) rx_bad = 1'b1;
            for (int c = 1; c < BAUD; c++) begin
                @(negedge clk);
                if (tx_out !== 1'b0 || tx_busy !== 1'b1 || frame_done !== 1'b0) rx_bad = 1'b1;
            end
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < BAUD; c++) begin
                    @(negedge clk);
                    if (c == 0) rx_got[b] = tx_out;
                    else if (tx_out !== rx_got[b]) rx_bad = 1'b1;
                    if (tx_busy !== 1'b1 || frame_done !== 1'b0) rx_bad = 1'b1;
                end
            end
`ifdef ALU_SER_PARITY_EN
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                if (tx_out !== ^rx_got || tx_busy !== 1'b1 || frame_done !== 1'b0) rx_bad = 1'b1;
            end
`endif
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                if (tx_out !== 1'b1 || tx_busy !== 1'b1) rx_bad = 1'b1;
                if (frame_done === 1'b1) begin
                    if (c == BAUD - 1) rx_fd++;
                    else rx_bad = 1'b1;
                end
            end
            check("rx_frame_shape", 32'(rx_bad), 0);
            check("rx_frame_done_once", 32'(rx_fd), 1);
            check("rx_frame_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rx_payload", 32'(rx_got), 32'(exp_q.pop_front()));
            n_frames++;
        end
    end

    task automatic push_word(input logic [5:0] d, input logic [1:0] s);
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sel = s;
        while (in_ready !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("push_ready_timeout", 32'(g >= 3000), 0);
        exp_q.push_back({d, s});
        n_expected++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (g < 5000) begin
            @(negedge clk);
            if (exp_q.size() == 0 && tx_busy === 1'b0 && level === 3'd0) break;
            g++;
        end
        check("drain_timeout", 32'(g >= 5000), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         acc, cnt, guard;
    logic       took, was_low, seen_low, prev_done;
    logic [11:0] seq1;

    initial begin : main
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0;
        in_valid1 = 1'b0; in_data1 = '0; in_sel1 = '0;
        repeat (2) @(negedge clk);
        check("reset_tx_out", 32'(tx_out), 1);
        check("reset_tx_busy", 32'(tx_busy), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_level", 32'(level), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Single word: start bit two cycles after push, frame length
        push_word(6'b000101, 2'b01);
        @(negedge clk);
        check("single_tx_before_start", 32'(tx_out), 1);
        check("single_level_after_push", 32'(level), 1);
        @(negedge clk);
        check("single_start_bit", 32'(tx_out), 0);
        check("single_busy", 32'(tx_busy), 1);
        check("single_level_after_pop", 32'(level), 0);
        cnt = 1;
        while (cnt < 2 * FRAME) begin
            @(negedge clk);
            if (tx_busy !== 1'b1) break;
            cnt++;
        end
        check("single_frame_len", 32'(cnt), 32'(FRAME));
        wait_idle();

        // Back-to-back: three words on consecutive edges, contiguous frames
        @(negedge clk);
        in_valid = 1'b1; in_data = 6'h15; in_sel = 2'b10;
        exp_q.push_back({in_data, in_sel}); n_expected++;
        @(negedge clk);
        check("b2b_level_1", 32'(level), 1);
        in_data = 6'h2A; in_sel = 2'b01;
        exp_q.push_back({in_data, in_sel}); n_expected++;
        @(negedge clk);
        check("b2b_level_push_pop", 32'(level), 1);
        check("b2b_busy", 32'(tx_busy), 1);
        in_data = 6'h33; in_sel = 2'b11;
        exp_q.push_back({in_data, in_sel}); n_expected++;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_level_2", 32'(level), 2);
        cnt = 2;
        while (cnt < 4 * FRAME) begin
            @(negedge clk);
            if (tx_busy !== 1'b1) break;
            cnt++;
            if (cnt == FRAME + 1) check("b2b_level_after_pop2", 32'(level), 1);
            if (cnt == 2 * FRAME + 1) check("b2b_level_after_pop3", 32'(level), 0);
        end
        check("b2b_contiguous_len", 32'(cnt), 32'(3 * FRAME));
        wait_idle();

        // Full FIFO: hold in_valid high and watch in_ready
        acc = 0; guard = 0; was_low = 1'b0; seen_low = 1'b0; prev_done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 6'(3); in_sel = 2'(0);
        while (acc < 8 && guard < 3000) begin
            took = in_ready;
            if (took) begin
                if (was_low) begin
                    check("full_ready_rise_after_pop", 32'(prev_done), 1);
                    was_low = 1'b0;
                end
                exp_q.push_back({in_data, in_sel});
                n_expected++;
                acc++;
            end else begin
                if (!seen_low) begin
                    seen_low = 1'b1;
                    check("full_drop_after_5", 32'(acc), 5);
                    check("full_level", 32'(level), 32'(DEPTH));
                end
                was_low = 1'b1;
            end
            prev_done = frame_done;
            @(negedge clk);
            guard++;
            if (took) begin
                if (acc < 8) begin
                    in_data = 6'(acc * 5 + 3); in_sel = 2'(acc);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("full_accept_all", 32'(acc), 8);
        wait_idle();

        // Mid-frame reset during DATA bit 3 with two words still buffered
        rx_en = 1'b0;
        push_word(6'h2A, 2'b10);
        push_word(6'h11, 2'b01);
        push_word(6'h3C, 2'b00);
        repeat (16) @(negedge clk);
        check("rst_pre_busy", 32'(tx_busy), 1);
        check("rst_pre_level", 32'(level), 2);
        rst = 1'b1;
        #1;
        check("rst_tx_out", 32'(tx_out), 1);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_level", 32'(level), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        n_expected -= exp_q.size();
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_discard_busy", 32'(tx_busy), 0);
        check("rst_discard_tx", 32'(tx_out), 1);
        rx_en = 1'b1;
        push_word(6'h27, 2'b11);
        wait_idle();

        // Wrap-around: 2*DEPTH+1 random words in order
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            push_word(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
        end
        wait_idle();

        // BAUD_DIV=1 instance: all-ones payload, one bit per cycle
        seq1 = '1;
        seq1[0] = 1'b0;
`ifdef ALU_SER_PARITY_EN
        seq1[9] = 1'b0;
`endif
        @(negedge clk);
        in_valid1 = 1'b1; in_data1 = 6'b111111; in_sel1 = 2'b11;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        check("b1_tx_before_start", 32'(tx_out1), 1);
        check("b1_level", 32'(level1), 1);
        for (int i = 0; i < NBITS; i++) begin
            @(negedge clk);
            check($sformatf("b1_bit%0d", i), 32'(tx_out1), 32'(seq1[i]));
            check($sformatf("b1_done%0d", i), 32'(frame_done1), 32'(i == NBITS - 1));
            check($sformatf("b1_busy%0d", i), 32'(tx_busy1), 1);
        end
        @(negedge clk);
        check("b1_idle_busy", 32'(tx_busy1), 0);
        check("b1_idle_tx", 32'(tx_out1), 1);

        check("frames_received", 32'(n_frames), 32'(n_expected));
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
